// File: rtl/codificador_serial.sv
// codificador_serial: encodes a 4-bit nibble into an 8-bit extended Hamming
// codeword (with optional single-bit error injection) and sends it as a serial
// frame: one low start bit, eight data bits LSB first, one high stop bit.
// Each bit lasts DIVISOR clock cycles.
module codificador_serial #(
    parameter int DIVISOR = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] conmutador_4,
    input  logic       iniciar,
    input  logic [3:0] inyectar_error,
    output logic [7:0] palabra_tx,
    output logic       tx_dato,
    output logic       ocupado,
    output logic       listo
);

    localparam logic [1:0] REPOSO = 2'd0;
    localparam logic [1:0] INICIO = 2'd1;
    localparam logic [1:0] DATOS  = 2'd2;
    localparam logic [1:0] PARADA = 2'd3;

    // Last value of the bit-period counter before moving to the next bit
    localparam logic [7:0] ULTIMO = 8'(DIVISOR - 1);

    logic [1:0] estado;
    logic [7:0] contador;
    logic [2:0] indice_bit;
    logic [7:0] palabra_cod;
    logic [7:0] mascara;
    logic       fin_bit;

    assign fin_bit = (contador == ULTIMO);

    // Hamming(7,4) encoding of the switch nibble plus an overall parity bit
    always_comb begin
        palabra_cod    = '0;
        palabra_cod[0] = conmutador_4[0] ^ conmutador_4[1] ^ conmutador_4[3];
        palabra_cod[1] = conmutador_4[0] ^ conmutador_4[2] ^ conmutador_4[3];
        palabra_cod[2] = conmutador_4[0];
        palabra_cod[3] = conmutador_4[1] ^ conmutador_4[2] ^ conmutador_4[3];
        palabra_cod[4] = conmutador_4[1];
        palabra_cod[5] = conmutador_4[2];
        palabra_cod[6] = conmutador_4[3];
        palabra_cod[7] = ^palabra_cod[6:0];
    end

    // Error injection mask: positions 1..8 flip one codeword bit, others none
    always_comb begin
        mascara = '0;
        if (inyectar_error >= 4'd1 && inyectar_error <= 4'd8) begin
            mascara = 8'b0000_0001 << (inyectar_error - 4'd1);
        end
    end

    // Frame sequencer: all outputs are registered so the line is glitch-free
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado     <= REPOSO;
            contador   <= '0;
            indice_bit <= '0;
            palabra_tx <= 8'h00;
            tx_dato    <= 1'b1;
            ocupado    <= 1'b0;
            listo      <= 1'b0;
        end else begin
            listo <= 1'b0;
            case (estado)
                REPOSO: begin
                    tx_dato <= 1'b1;
                    if (iniciar) begin
                        palabra_tx <= palabra_cod ^ mascara;
                        estado     <= INICIO;
                        contador   <= '0;
                        indice_bit <= '0;
                        tx_dato    <= 1'b0;
                        ocupado    <= 1'b1;
                    end
                end
                INICIO: begin
                    if (fin_bit) begin
                        contador   <= '0;
                        indice_bit <= '0;
                        estado     <= DATOS;
                        tx_dato    <= palabra_tx[0];
                    end else begin
                        contador <= contador + 8'd1;
                    end
                end
                DATOS: begin
                    if (fin_bit) begin
                        contador <= '0;
                        if (indice_bit == 3'd7) begin
                            estado  <= PARADA;
                            tx_dato <= 1'b1;
                        end else begin
                            indice_bit <= indice_bit + 3'd1;
                            tx_dato    <= palabra_tx[indice_bit + 3'd1];
                        end
                    end else begin
                        contador <= contador + 8'd1;
                    end
                end
                PARADA: begin
                    if (fin_bit) begin
                        contador <= '0;
                        estado   <= REPOSO;
                        ocupado  <= 1'b0;
                        listo    <= 1'b1;
                        tx_dato  <= 1'b1;
                    end else begin
                        contador <= contador + 8'd1;
                    end
                end
                default: begin
                    estado   <= REPOSO;
                    contador <= '0;
                    tx_dato  <= 1'b1;
                    ocupado  <= 1'b0;
                end
            endcase
        end
    end

endmodule
